// File: rtl/uart_alu_intf.sv
// Command sequencer between the UART RX/TX FIFOs and an 8-bit ALU: pops A, B, opcode; pushes result.
// Optional status byte after the result when UART_ALU_STATUS_EN is defined.
//
// state    | meaning
// GET_A    | wait for / pop operand A
// GET_B    | wait for / pop operand B
// GET_OP   | wait for / pop opcode byte
// EXEC     | compute and register result (and flags)
// SEND_RES | push result byte when TX not full
// SEND_ST  | push status byte when TX not full (status build only)

module uart_alu_intf #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx_empty,
  input  logic [DBIT-1:0] i_r_data,
  output logic            o_rd_uart,
  input  logic            i_tx_full,
  output logic            o_wr_uart,
  output logic [DBIT-1:0] o_w_data
);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(8'h20);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(8'h22);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(8'h24);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(8'h25);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(8'h26);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(8'h27);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(8'h02);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(8'h03);
  localparam logic [DBIT-1:0]  SH_LIM = DBIT'(DBIT);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    SEND_RES
`ifdef UART_ALU_STATUS_EN
    , SEND_ST
`endif
  } state_t;

  state_t            state;
  logic [DBIT-1:0]   a_q;
  logic [DBIT-1:0]   b_q;
  logic [NB_OP-1:0]  op_q;
  logic [DBIT-1:0]   res_q;
  logic [DBIT-1:0]   alu_res;
  logic              rd_state;
  logic              wr_state;

`ifdef UART_ALU_STATUS_EN
  logic              carry_q;
  logic              zero_q;
  logic              inv_q;
  logic              alu_carry;
  logic              alu_inv;
  logic [DBIT-1:0]   status_byte;
`endif

  always_comb begin
    alu_res = '0;
`ifdef UART_ALU_STATUS_EN
    alu_carry = 1'b0;
    alu_inv   = 1'b0;
`endif
    case (op_q)
      OP_ADD: begin
`ifdef UART_ALU_STATUS_EN
        {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
`else
        alu_res = a_q + b_q;
`endif
      end
      OP_SUB: begin
        alu_res = a_q - b_q;
`ifdef UART_ALU_STATUS_EN
        alu_carry = (a_q < b_q);
`endif
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      // oversize shift amounts saturate explicitly rather than relying on operator semantics
      OP_SRL: alu_res = (b_q >= SH_LIM) ? '0 : (a_q >> b_q);
      OP_SRA: alu_res = (b_q >= SH_LIM) ? {DBIT{a_q[DBIT-1]}} : DBIT'($signed(a_q) >>> b_q);
      default: begin
        alu_res = '0;
`ifdef UART_ALU_STATUS_EN
        alu_inv = 1'b1;
`endif
      end
    endcase
  end

`ifdef UART_ALU_STATUS_EN
  always_comb begin
    status_byte    = '0;
    status_byte[0] = carry_q;
    status_byte[1] = zero_q;
    status_byte[DBIT-1] = inv_q;
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= GET_A;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
`ifdef UART_ALU_STATUS_EN
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      inv_q   <= 1'b0;
`endif
    end else begin
      case (state)
        GET_A: begin
          if (!i_rx_empty) begin
            a_q   <= i_r_data;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (!i_rx_empty) begin
            b_q   <= i_r_data;
            state <= GET_OP;
          end
        end
        GET_OP: begin
          if (!i_rx_empty) begin
            op_q  <= i_r_data[NB_OP-1:0];
            state <= EXEC;
          end
        end
        EXEC: begin
          res_q <= alu_res;
`ifdef UART_ALU_STATUS_EN
          carry_q <= alu_carry;
          zero_q  <= (alu_res == '0);
          inv_q   <= alu_inv;
`endif
          state <= SEND_RES;
        end
        SEND_RES: begin
          if (!i_tx_full) begin
`ifdef UART_ALU_STATUS_EN
            state <= SEND_ST;
`else
            state <= GET_A;
`endif
          end
        end
`ifdef UART_ALU_STATUS_EN
        SEND_ST: begin
          if (!i_tx_full) state <= GET_A;
        end
`endif
        default: state <= GET_A;
      endcase
    end
  end

  always_comb begin
    rd_state = (state == GET_A) || (state == GET_B) || (state == GET_OP);
`ifdef UART_ALU_STATUS_EN
    wr_state = (state == SEND_RES) || (state == SEND_ST);
`else
    wr_state = (state == SEND_RES);
`endif
  end

  // strobes are gated by reset directly so they drop the instant reset asserts
  assign o_rd_uart = i_reset && rd_state && !i_rx_empty;
  assign o_wr_uart = i_reset && wr_state && !i_tx_full;

`ifdef UART_ALU_STATUS_EN
  assign o_w_data = (state == SEND_ST) ? status_byte : res_q;
`else
  assign o_w_data = res_q;
`endif

endmodule

// File: tb/tb_uart_alu_intf.sv
// Directed bench for uart_alu_intf: FIFO models on both sides, hand-computed results.
// Status byte expectations apply when UART_ALU_STATUS_EN is defined.

module tb_uart_alu_intf;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_rx_empty = 1'b1;
  logic [7:0] i_r_data = 8'h00;
  logic       i_tx_full = 1'b0;
  logic       o_rd_uart;
  logic       o_wr_uart;
  logic [7:0] o_w_data;

`ifdef UART_ALU_STATUS_EN
  localparam int NTX = 2;
`else
  localparam int NTX = 1;
`endif

  uart_alu_intf #(.DBIT(8), .NB_OP(6)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rx_empty (i_rx_empty),
    .i_r_data   (i_r_data),
    .o_rd_uart  (o_rd_uart),
    .i_tx_full  (i_tx_full),
    .o_wr_uart  (o_wr_uart),
    .o_w_data   (o_w_data)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rd_empty_cnt = 0;
  int both_cnt = 0;
  logic rd_s;
  logic wr_s;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_rx();
    i_rx_empty = (rx_q.size() == 0);
    i_r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  endtask

  // sample strobes mid-cycle, then let the FIFO models react to the edge
  task automatic tick();
    @(negedge i_clk);
    rd_s = o_rd_uart;
    wr_s = o_wr_uart;
    if (rd_s && i_rx_empty) rd_empty_cnt++;
    if (rd_s && wr_s) both_cnt++;
    if (wr_s) tx_q.push_back(o_w_data);
    @(posedge i_clk);
    #1;
    cyc++;
    if (rd_s) begin
      rd_cnt++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    drive_rx();
  endtask

  task automatic check_tx(input string tag, input logic [7:0] res, input logic [7:0] st);
    chk({tag, "_n"}, tx_q.size(), NTX);
    chk({tag, "_res"}, (tx_q.size() > 0) ? {24'h0, tx_q[0]} : 32'hDEAD, {24'h0, res});
`ifdef UART_ALU_STATUS_EN
    chk({tag, "_st"}, (tx_q.size() > 1) ? {24'h0, tx_q[1]} : 32'hDEAD, {24'h0, st});
`else
    if (st == 8'hFF) $display("note: unexpected status tag %s", tag);
`endif
  endtask

  task automatic wait_tx();
    for (int i = 0; i < 40 && tx_q.size() < NTX; i++) tick();
    repeat (3) tick();
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] res, input logic [7:0] st);
    int t0;
    int lat;
    tx_q.delete();
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(op);
    drive_rx();
    t0  = cyc;
    lat = -1;
    for (int i = 0; i < 40 && tx_q.size() < NTX; i++) begin
      tick();
      if (lat < 0 && tx_q.size() > 0) lat = cyc - t0;
    end
    repeat (3) tick();
    chk({tag, "_lat"}, lat, 5);
    check_tx(tag, res, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    drive_rx();
    i_reset = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_rd", o_rd_uart, 0);
    chk("rst_wr", o_wr_uart, 0);
    chk("rst_wdata", o_w_data, 8'h00);
    i_reset = 1'b1;

    run_cmd("add",     8'h05, 8'h03, 8'h20, 8'h08, 8'h00);
    run_cmd("sub_brw", 8'h03, 8'h05, 8'h22, 8'hFE, 8'h01);
    run_cmd("sra",     8'h80, 8'h02, 8'h03, 8'hE0, 8'h00);
    run_cmd("srl",     8'h80, 8'h02, 8'h02, 8'h20, 8'h00);
    run_cmd("sra_big", 8'h80, 8'h09, 8'h03, 8'hFF, 8'h00);
    run_cmd("add_cz",  8'hFF, 8'h01, 8'h20, 8'h00, 8'h03);
    run_cmd("and",     8'hF0, 8'h3C, 8'h24, 8'h30, 8'h00);
    run_cmd("or_hi",   8'h0F, 8'hF0, 8'hE5, 8'hFF, 8'h00);
    run_cmd("xor",     8'hAA, 8'hFF, 8'h26, 8'h55, 8'h00);
    run_cmd("nor",     8'h0F, 8'h30, 8'h27, 8'hC0, 8'h00);
    run_cmd("srl_big", 8'h80, 8'h08, 8'h02, 8'h00, 8'h02);
    run_cmd("sub_eq",  8'h05, 8'h05, 8'h22, 8'h00, 8'h02);
    run_cmd("sra_pos", 8'h70, 8'h04, 8'h03, 8'h07, 8'h00);

    // invalid opcode with TX backpressure after EXEC
    tx_q.delete();
    i_tx_full = 1'b1;
    rx_q.push_back(8'h12);
    rx_q.push_back(8'h34);
    rx_q.push_back(8'h3F);
    drive_rx();
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_wr", wr_s, 0);
      chk("bp_wdata", o_w_data, 8'h00);
    end
    i_tx_full = 1'b0;
    wait_tx();
    check_tx("inv_bp", 8'h00, 8'h82);

    // reset after A and B have been popped
    tx_q.delete();
    r0 = rd_cnt;
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    drive_rx();
    for (int i = 0; i < 20 && (rd_cnt - r0) < 2; i++) tick();
    chk("mid_pops", rd_cnt - r0, 2);
    i_reset = 1'b0;
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h20);
    drive_rx();
    repeat (2) begin
      @(posedge i_clk);
      #1;
      chk("mid_rst_rd", o_rd_uart, 0);
      chk("mid_rst_wdata", o_w_data, 8'h00);
    end
    i_reset = 1'b1;
    wait_tx();
    check_tx("mid_rst", 8'h02, 8'h00);

    // RX bytes trickling in 50 cycles apart
    tx_q.delete();
    r0 = rd_cnt;
    begin
      logic [7:0] stall_bytes [3];
      stall_bytes[0] = 8'h07;
      stall_bytes[1] = 8'h09;
      stall_bytes[2] = 8'h20;
      for (int i = 0; i < 3; i++) begin
        rx_q.push_back(stall_bytes[i]);
        drive_rx();
        repeat (50) tick();
        chk("stall_pops", rd_cnt - r0, i + 1);
      end
    end
    check_tx("stall", 8'h10, 8'h00);

    chk("rd_while_empty", rd_empty_cnt, 0);
    chk("rd_and_wr", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
